// File: rtl/imm_ext_pipe.sv
// Pipelined RISC-V immediate extender with a registered 2-entry skid FIFO.
// Optional macro IMM_EXT_ILLEGAL_EN adds the out_illegal flag for reserved/mismatched selects.
module imm_ext_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag
`ifdef IMM_EXT_ILLEGAL_EN
   ,
   output logic             out_illegal
`endif
);

   logic [31:0]      imm32_s;
   logic [5:0]       zeroVal_s;
   logic             useZero_s;
   logic [XLEN-1:0]  immExt_s;
   logic             push_s;
   logic             pop_s;
   logic             unusedOpcode_s;

   logic [XLEN-1:0]  immMem_r [2];
   logic [TAG_W-1:0] tagMem_r [2];
   logic [1:0]       count_r;
   logic             rdPtr_r;
   logic             wrPtr_r;

   // Decode the immediate for the selected format and extend it to XLEN.
   always_comb begin
      imm32_s   = 32'd0;
      zeroVal_s = 6'd0;
      useZero_s = 1'b0;
      case (in_imm_src)
         3'b000: imm32_s = {{21{in_instr[31]}}, in_instr[30:20]};
         3'b001: imm32_s = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
         3'b010: imm32_s = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
         3'b011: imm32_s = {in_instr[31:12], 12'd0};
         3'b100: imm32_s = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
         3'b101: begin
            useZero_s = 1'b1;
            if (XLEN == 64) begin
               zeroVal_s = in_instr[25:20];
            end else begin
               zeroVal_s = {1'b0, in_instr[24:20]};
            end
         end
         3'b110: begin
            useZero_s = 1'b1;
            zeroVal_s = {1'b0, in_instr[19:15]};
         end
         default: begin
            useZero_s = 1'b1;
            zeroVal_s = 6'd0;
         end
      endcase
      if (useZero_s) begin
         immExt_s = XLEN'(zeroVal_s);
      end else begin
         immExt_s = XLEN'($signed(imm32_s));
      end
   end

   assign unusedOpcode_s = ^in_instr[6:0];

`ifdef IMM_EXT_ILLEGAL_EN
   logic illegal_s;
   logic illMem_r [2];

   // Flag the reserved select and B/J selects whose opcode disagrees.
   always_comb begin
      illegal_s = 1'b0;
      case (in_imm_src)
         3'b010:  illegal_s = (in_instr[6:0] != 7'b1100011);
         3'b100:  illegal_s = (in_instr[6:0] != 7'b1101111);
         3'b111:  illegal_s = 1'b1;
         default: illegal_s = 1'b0;
      endcase
   end

   // Illegal-flag storage alongside the data entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illMem_r[0] <= 1'b0;
         illMem_r[1] <= 1'b0;
      end else if (push_s) begin
         illMem_r[wrPtr_r] <= illegal_s;
      end
   end

   assign out_illegal = illMem_r[rdPtr_r];
`endif

   // in_ready comes from registered count only, so out_ready never reaches decode.
   assign in_ready  = (count_r != 2'd2);
   assign out_valid = (count_r != 2'd0);
   assign push_s    = in_valid && in_ready;
   assign pop_s     = out_valid && out_ready;

   // FIFO storage, pointers and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         immMem_r[0] <= {XLEN{1'b0}};
         immMem_r[1] <= {XLEN{1'b0}};
         tagMem_r[0] <= {TAG_W{1'b0}};
         tagMem_r[1] <= {TAG_W{1'b0}};
         count_r     <= 2'd0;
         rdPtr_r     <= 1'b0;
         wrPtr_r     <= 1'b0;
      end else begin
         if (push_s) begin
            immMem_r[wrPtr_r] <= immExt_s;
            tagMem_r[wrPtr_r] <= in_tag;
            wrPtr_r           <= ~wrPtr_r;
         end
         if (pop_s) begin
            rdPtr_r <= ~rdPtr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign out_imm = immMem_r[rdPtr_r];
   assign out_tag = tagMem_r[rdPtr_r];

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe (XLEN=32 and XLEN=64 instances).
module tb_imm_ext_pipe;

   logic        clk;
   logic        rstN;
   logic        inValid;
   logic [31:0] inInstr;
   logic [2:0]  inImmSrc;
   logic [4:0]  inTag;
   logic        outReady;
   logic        outReady64;
   logic        inReady32, outValid32, inReady64, outValid64;
   logic [31:0] outImm32;
   logic [63:0] outImm64;
   logic [4:0]  outTag32, outTag64;
`ifdef IMM_EXT_ILLEGAL_EN
   logic        outIll32, outIll64;
`endif

   int checks = 0;
   int errors = 0;

   imm_ext_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady32),
      .in_instr(inInstr), .in_imm_src(inImmSrc), .in_tag(inTag),
      .out_valid(outValid32), .out_ready(outReady), .out_imm(outImm32), .out_tag(outTag32)
`ifdef IMM_EXT_ILLEGAL_EN
      , .out_illegal(outIll32)
`endif
   );

   imm_ext_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .in_ready(inReady64),
      .in_instr(inInstr), .in_imm_src(inImmSrc), .in_tag(inTag),
      .out_valid(outValid64), .out_ready(outReady64), .out_imm(outImm64), .out_tag(outTag64)
`ifdef IMM_EXT_ILLEGAL_EN
      , .out_illegal(outIll64)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sendOne(input string tag, input logic [31:0] instr, input logic [2:0] src,
                          input logic [31:0] expImm, input logic expIll);
      inValid  = 1'b1;
      inInstr  = instr;
      inImmSrc = src;
      inTag    = 5'd7;
      checkVal({tag, "_rdy"}, 64'(inReady32), 64'd1);
      step();
      inValid = 1'b0;
      checkVal({tag, "_vld"}, 64'(outValid32), 64'd1);
      checkVal({tag, "_imm"}, 64'(outImm32), 64'(expImm));
      checkVal({tag, "_tag"}, 64'(outTag32), 64'd7);
`ifdef IMM_EXT_ILLEGAL_EN
      checkVal({tag, "_ill"}, 64'(outIll32), 64'(expIll));
`else
      if (expIll) checkVal({tag, "_noill"}, 64'(outImm32), 64'd0);
`endif
      step();
      checkVal({tag, "_drain"}, 64'(outValid32), 64'd0);
   endtask

   task automatic send64(input string tag, input logic [31:0] instr, input logic [2:0] src,
                         input logic [63:0] expImm);
      inValid  = 1'b1;
      inInstr  = instr;
      inImmSrc = src;
      inTag    = 5'd3;
      step();
      inValid = 1'b0;
      checkVal({tag, "_vld"}, 64'(outValid64), 64'd1);
      checkVal({tag, "_imm"}, outImm64, expImm);
      checkVal({tag, "_tag"}, 64'(outTag64), 64'd3);
      step();
   endtask

   initial begin
      logic [36:0] q[$];
      logic [11:0] b;
      int sent, recv, cyc;

      rstN       = 1'b0;
      inValid    = 1'b0;
      inInstr    = 32'd0;
      inImmSrc   = 3'd0;
      inTag      = 5'd0;
      outReady   = 1'b1;
      outReady64 = 1'b1;
      #3;
      checkVal("rst_rdy", 64'(inReady32), 64'd1);
      checkVal("rst_vld", 64'(outValid32), 64'd0);
      checkVal("rst_imm", 64'(outImm32), 64'd0);
      checkVal("rst_tag", 64'(outTag32), 64'd0);
      #10 rstN = 1'b1;
      step();

      // Format sweep at XLEN=32
      sendOne("fmtI", 32'h80000013, 3'b000, 32'hFFFFF800, 1'b0);
      sendOne("fmtS", 32'hFE000FA3, 3'b001, 32'hFFFFFFFF, 1'b0);
      sendOne("fmtB", 32'h80000063, 3'b010, 32'hFFFFF000, 1'b0);
      sendOne("fmtU", 32'hAAAAA037, 3'b011, 32'hAAAAA000, 1'b0);
      sendOne("fmtJ", 32'h8000006F, 3'b100, 32'hFFF00000, 1'b0);
      sendOne("fmtSh", 32'h01F00013, 3'b101, 32'h0000001F, 1'b0);
      sendOne("fmtZ", 32'h000FD073, 3'b110, 32'h0000001F, 1'b0);
      sendOne("fmtRsv", 32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1);
`ifdef IMM_EXT_ILLEGAL_EN
      sendOne("badB", 32'h80000013, 3'b010, 32'hFFFFF000, 1'b1);
      sendOne("badJ", 32'h80000013, 3'b100, 32'hFFF00000, 1'b1);
`endif

      // XLEN=64 instance
      send64("u64", 32'h80000037, 3'b011, 64'hFFFFFFFF80000000);
      send64("sh64", 32'h03F01013, 3'b101, 64'h000000000000003F);

      // Back-pressure: two absorbed, third held off, delivered in order
      outReady = 1'b0;
      inValid  = 1'b1;
      inImmSrc = 3'b000;
      inInstr  = {12'd1, 20'h00013}; inTag = 5'd1;
      step();
      checkVal("bp1_rdy", 64'(inReady32), 64'd1);
      checkVal("bp1_tag", 64'(outTag32), 64'd1);
      inInstr  = {12'd2, 20'h00013}; inTag = 5'd2;
      step();
      checkVal("bp2_rdy", 64'(inReady32), 64'd0);
      checkVal("bp2_tag", 64'(outTag32), 64'd1);
      inInstr  = {12'd3, 20'h00013}; inTag = 5'd3;
      step();
      checkVal("bp3_rdy", 64'(inReady32), 64'd0);
      checkVal("bp3_tag", 64'(outTag32), 64'd1);
      checkVal("bp3_imm", 64'(outImm32), 64'd1);
      outReady = 1'b1;
      step();
      checkVal("bp4_tag", 64'(outTag32), 64'd2);
      checkVal("bp4_imm", 64'(outImm32), 64'd2);
      checkVal("bp4_rdy", 64'(inReady32), 64'd1);
      step();
      inValid = 1'b0;
      checkVal("bp5_tag", 64'(outTag32), 64'd3);
      checkVal("bp5_vld", 64'(outValid32), 64'd1);
      step();
      checkVal("bp6_vld", 64'(outValid32), 64'd0);

      // Reset with two entries buffered
      outReady = 1'b0;
      inValid  = 1'b1;
      inInstr  = {12'd5, 20'h00013}; inTag = 5'd5;
      step();
      inInstr  = {12'd6, 20'h00013}; inTag = 5'd6;
      step();
      inValid = 1'b0;
      checkVal("mr_full", 64'(inReady32), 64'd0);
      #2 rstN = 1'b0;
      #1;
      checkVal("mr_vld", 64'(outValid32), 64'd0);
      checkVal("mr_rdy", 64'(inReady32), 64'd1);
      #2 rstN = 1'b1;
      outReady = 1'b1;
      inValid  = 1'b1;
      inInstr  = {12'd9, 20'h00013}; inTag = 5'd9;
      step();
      inValid = 1'b0;
      checkVal("mr_nvld", 64'(outValid32), 64'd1);
      checkVal("mr_ntag", 64'(outTag32), 64'd9);
      checkVal("mr_nimm", 64'(outImm32), 64'd9);
      step();
      checkVal("mr_alone", 64'(outValid32), 64'd0);

      // Random back-pressure streaming against a scoreboard queue
      sent = 0;
      recv = 0;
      cyc  = 0;
      b    = 12'd0;
      while (recv < 200 && cyc < 3000) begin
         checkVal("st_vld", 64'(outValid32), 64'(q.size() != 0));
         checkVal("st_occ", 64'(q.size() <= 2), 64'd1);
         outReady = 1'($urandom_range(0, 1));
         if (sent < 200) begin
            inValid  = 1'b1;
            b        = 12'($urandom_range(0, 4095));
            inInstr  = {b, 20'h00013};
            inImmSrc = 3'b000;
            inTag    = sent[4:0];
         end else begin
            inValid = 1'b0;
         end
         if (outValid32 && outReady) begin
            if (q.size() == 0) begin
               checkVal("st_extra", 64'd1, 64'd0);
            end else begin
               checkVal("st_data", 64'({outImm32, outTag32}), 64'(q[0]));
               void'(q.pop_front());
            end
            recv++;
         end
         if (inValid && inReady32) begin
            q.push_back({{20{b[11]}}, b, inTag});
            sent++;
         end
         step();
         cyc++;
      end
      checkVal("st_recv", 64'(recv), 64'd200);
      checkVal("st_empty", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Pipelined, parametrised immediate extender for the RISC-V decode stage. It accepts an instruction word with an immediate-source select and a tag over a valid/ready handshake. It produces the sign- or zero-extended immediate at XLEN bits through a registered 2-entry skid buffer, so back-pressure from execute never stalls decode combinationally. Compared with the single-cycle combinational extender, it adds XLEN generalisation, shift-amount and CSR-zimm modes, tag pass-through, and flow control.

## Interface
- XLEN, 32, output immediate width; legal values 32 or 64
- TAG_W, 5, width of the opaque tag carried alongside each request (e.g. rd index)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request this cycle
- in_instr  input  32  instruction word
- in_imm_src  input  3  immediate format select
- in_tag  input  TAG_W  tag, returned unchanged with the result
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- out_imm  output  XLEN  extended immediate
- out_tag  output  TAG_W  tag of the current result
- out_illegal  output  1  only present with IMM_EXT_ILLEGAL_EN; set for a reserved select code

## Operation
- Immediate formed combinationally from in_instr/in_imm_src; stored already extended. s = in_instr[31] sign-extends to XLEN.
  - 000 I: s, instr[30:20]
  - 001 S: s, instr[30:25], instr[11:7]
  - 010 B: s, instr[7], instr[30:25], instr[11:8], 0
  - 011 U: s, instr[30:12], 12'b0; sign-extended above bit 31 when XLEN=64
  - 100 J: s, instr[19:12], instr[20], instr[30:21], 0
  - 101 SHAMT: zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64)
  - 110 ZIMM: zero-extended instr[19:15] (CSR immediate forms)
  - 111 reserved: result 0
- Storage is a 2-entry FIFO (entries: imm, tag, illegal), with a 2-bit count, read pointer, and write pointer. Order is strictly preserved.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- in_ready = (count != 2); it depends only on registered state, with no combinational path from out_ready.
- out_valid = (count != 0). out_imm, out_tag and out_illegal show the head entry and are held stable while out_valid && !out_ready.
- Count transitions per cycle: push only +1; pop only −1; push and pop together, unchanged. Push while count==2 is impossible because in_ready is low.
- Pointers wrap modulo 2.

## Timing
- Latency 1 cycle: a request accepted at edge N appears on out_* with out_valid=1 after edge N. This holds when the FIFO was empty.
- Throughput 1 result per cycle while out_ready stays high.
- With out_ready low, 2 requests are absorbed. in_ready falls after the edge that stores the second request. It rises again after the first pop.
- Simultaneous push and pop at count==1: the head advances, the new entry is queued behind it, and count stays 1.
- Reset (asynchronous assert, any time, including mid-transfer): count=0, pointers=0, out_valid=0, out_imm=0, out_tag=0, out_illegal=0, in_ready=1. Buffered entries are discarded. The first accept is possible on the first edge after rst_n deasserts.
- out_* are undefined-but-stable while out_valid=0; the bench must not check them then.

## Configuration
- IMM_EXT_ILLEGAL_EN defined:
  - out_illegal port exists.
  - Code 111 stores illegal=1 with imm=0.
  - B or J selects whose instr[6:0] is not 1100011 / 1101111 respectively also set illegal=1, with the immediate still computed.
- Undefined: port and storage bit absent; code 111 yields imm=0 silently.

## Test plan
- Reset mid-stream with 2 entries buffered -> out_valid=0, in_ready=1 immediately; the next accepted request appears alone 1 cycle later.
- Format sweep, XLEN=32, out_ready=1:
  - 0x80000013/000 -> 0xFFFFF800
  - 0xFE000FA3/001 -> 0xFFFFFFFF
  - 0x80000063/010 -> 0xFFFFF000
  - 0xAAAAA037/011 -> 0xAAAAA000
  - 0x8000006F/100 -> 0xFFF00000
  - 0x01F00013/101 -> 0x0000001F
  - 0x000FD073/110 -> 0x0000001F
- XLEN=64: 0x80000037/011 -> 0xFFFFFFFF80000000; 0x03F01013/101 -> 0x3F.
- Back-pressure: out_ready=0 while 3 requests are offered with tags 1,2,3 -> tags 1,2 accepted, in_ready=0 holds off 3. Release out_ready -> tags delivered 1,2,3 in order, with head values stable while stalled.
- Streaming with random out_ready at 50%, 200 requests -> no loss, no duplication, order kept, count never exceeds 2.
- IMM_EXT_ILLEGAL_EN: select 111 -> out_imm=0, out_illegal=1; 0x80000013 with select 010 -> out_illegal=1. Without the macro, select 111 -> out_imm=0.
